// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, hazard FSM states, counter width and helpers.
package lc3_pkg;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, INJECT} hazState_e;

  // Register usage of one decoded instruction.
  typedef struct packed {
    logic [7:0] srcMask;   // one bit per source register read
    logic       dstValid;  // writes a register
    logic [2:0] dstReg;
    logic       ccWrite;   // writes condition codes
    logic       isBr;      // conditional branch, reads CC
  } regDep_t;

  // Saturating counter update: one increment, up to two decrements.
  // Decrementing past zero is a protocol error and holds at zero.
  function automatic logic [CNT_W-1:0] cntNext(input logic [CNT_W-1:0] cur,
                                               input logic inc,
                                               input logic decA,
                                               input logic decB);
    logic [CNT_W+1:0] up, down;
    up   = {2'b00, cur} + (CNT_W+2)'(inc);
    down = (CNT_W+2)'(decA) + (CNT_W+2)'(decB);
    if (up <= down) return '0;
    if ((up - down) > {2'b00, CNT_MAX}) return CNT_MAX;
    return CNT_W'(up - down);
  endfunction

endpackage

// File: rtl/lc3_regdep.sv
// Combinational source/destination/CC decoder for a single LC-3 instruction.
import lc3_pkg::*;

module lc3_regdep (
  input  logic [15:0] ir,
  output regDep_t     dep
);

  // Classify register and CC usage by opcode.
  always_comb begin
    dep = '0;
    case (ir[15:12])
      OP_ADD, OP_AND: begin
        dep.srcMask[ir[8:6]] = 1'b1;
        if (!ir[5]) dep.srcMask[ir[2:0]] = 1'b1;
        dep.dstValid = 1'b1;
        dep.dstReg   = ir[11:9];
        dep.ccWrite  = 1'b1;
      end
      OP_NOT, OP_LDR: begin
        dep.srcMask[ir[8:6]] = 1'b1;
        dep.dstValid = 1'b1;
        dep.dstReg   = ir[11:9];
        dep.ccWrite  = 1'b1;
      end
      OP_LD, OP_LDI, OP_LEA: begin
        dep.dstValid = 1'b1;
        dep.dstReg   = ir[11:9];
        dep.ccWrite  = 1'b1;
      end
      OP_JMP: dep.srcMask[ir[8:6]] = 1'b1;
      OP_JSR: begin
        // bit 11 clear selects JSRR, which reads its base register
        if (!ir[11]) dep.srcMask[ir[8:6]] = 1'b1;
        dep.dstValid = 1'b1;
        dep.dstReg   = 3'd7;
      end
      OP_TRAP: begin
        dep.dstValid = 1'b1;
        dep.dstReg   = 3'd7;
      end
      OP_ST, OP_STI: dep.srcMask[ir[11:9]] = 1'b1;
      OP_STR: begin
        dep.srcMask[ir[11:9]] = 1'b1;
        dep.srcMask[ir[8:6]]  = 1'b1;
      end
      OP_RTI: dep.srcMask[6] = 1'b1;
      OP_BR:  dep.isBr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard control: scoreboards in-flight register/CC writers,
// stalls dependent instructions, and sequences branch flush and interrupt entry.
import lc3_pkg::*;

module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ifIR,
  input  logic        ifValid,
  input  logic        wbEn,
  input  logic [2:0]  wbDR,
  input  logic        wbCC,
  input  logic        brTaken,
  input  logic        intReq,
  output logic        pause,
  output logic        flush,
  output logic        irq,
  output logic        intAck,
  output logic [7:0]  busyMask
);

  regDep_t          dep;
  hazState_e        state, stateNext;
  logic [CNT_W-1:0] cnt  [8];
  logic [CNT_W-1:0] cntD [8];
  logic [CNT_W-1:0] ccCnt, ccD;
  logic             flushSecond, intArmed, intTrig;
  logic             lastValid, lastDstValid, lastCc;
  logic [2:0]       lastDst;
  logic             issue, squash, allIdle;

  lc3_regdep uDep (.ir(ifIR), .dep(dep));

  assign issue   = ifValid && (state == RUN) && !pause && !flush;
  assign squash  = brTaken && lastValid;
  assign allIdle = (busyMask == 8'h00) && (ccCnt == '0);
  assign intTrig = intReq && intArmed;

  // Stall on RAW against any in-flight writer, BR waiting on CC, a saturated
  // destination counter, or any non-RUN state. A saturated CC counter also
  // stalls a CC writer so that counter can never overflow.
  always_comb begin
    pause = (state != RUN);
    if ((dep.srcMask & busyMask) != 8'h00)              pause = 1'b1;
    if (dep.isBr && (ccCnt != '0))                      pause = 1'b1;
    if (dep.dstValid && (cnt[dep.dstReg] == CNT_MAX))   pause = 1'b1;
    if (dep.ccWrite && (ccCnt == CNT_MAX))              pause = 1'b1;
  end

  for (genvar r = 0; r < 8; r++) begin : gReg
    logic inc, decWb, decSq;
    assign inc      = issue && dep.dstValid && (dep.dstReg == 3'(r));
    assign decWb    = wbEn && (wbDR == 3'(r));
    assign decSq    = squash && lastDstValid && (lastDst == 3'(r));
    assign cntD[r]  = cntNext(cnt[r], inc, decWb, decSq);
    assign busyMask[r] = (cnt[r] != '0);
  end

  assign ccD = cntNext(ccCnt, issue && dep.ccWrite, wbCC, squash && lastCc);

  // Writer counters: issue increments, write-back and squash decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 8; r++) cnt[r] <= '0;
      ccCnt <= '0;
    end else begin
      for (int r = 0; r < 8; r++) cnt[r] <= cntD[r];
      ccCnt <= ccD;
    end
  end

  // Remember the last issued instruction so a redirect can undo its counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastValid    <= 1'b0;
      lastDstValid <= 1'b0;
      lastDst      <= '0;
      lastCc       <= 1'b0;
    end else if (issue) begin
      lastValid    <= 1'b1;
      lastDstValid <= dep.dstValid;
      lastDst      <= dep.dstReg;
      lastCc       <= dep.ccWrite;
    end else if (squash) begin
      lastValid    <= 1'b0;
    end
  end

  // Next-state: redirect beats interrupt; FLUSH lasts two cycles and hands a
  // pending interrupt straight to DRAIN.
  always_comb begin
    stateNext = state;
    case (state)
      RUN:    if (brTaken) stateNext = FLUSH;
              else if (intTrig) stateNext = DRAIN;
      FLUSH:  if (flushSecond) stateNext = intTrig ? DRAIN : RUN;
      DRAIN:  if (allIdle) stateNext = INJECT;
      INJECT: stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      flushSecond <= 1'b0;
      flush       <= 1'b0;
      irq         <= 1'b0;
      intAck      <= 1'b0;
    end else begin
      state       <= stateNext;
      flushSecond <= (state == FLUSH) ? !flushSecond : 1'b0;
      flush       <= (stateNext == FLUSH);
      irq         <= (stateNext == INJECT);
      intAck      <= (stateNext == INJECT);
    end
  end

  // Interrupt re-arms only after intReq has been seen low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 intArmed <= 1'b1;
    else if (state == INJECT)  intArmed <= 1'b0;
    else if (!intReq)          intArmed <= 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ifIR = 16'hD000;
  logic        ifValid = 1'b0, wbEn = 1'b0, wbCC = 1'b0, brTaken = 1'b0, intReq = 1'b0;
  logic [2:0]  wbDR = 3'd0;
  logic        pause, flush, irq, intAck;
  logic [7:0]  busyMask;

  localparam logic [15:0] IDLE  = 16'hD000; // reserved opcode: no registers
  localparam logic [15:0] ADD1  = 16'h1283; // ADD R1,R2,R3
  localparam logic [15:0] ADD4  = 16'h1861; // ADD R4,R1,#1
  localparam logic [15:0] LD2   = 16'h2400; // LD  R2,#0
  localparam logic [15:0] BRZ   = 16'h0400; // BRz #0
  localparam logic [15:0] ADD5  = 16'h1B60; // ADD R5,R5,#0
  localparam logic [15:0] LDR3  = 16'h6600; // LDR R3,R0,#0
  localparam logic [15:0] ADD10 = 16'h1220; // ADD R1,R0,#0

  typedef struct {
    string      nm;
    logic [11:0] exp;
  } expT;

  expT expQ[$];
  expT mt;
  int  errors = 0;
  int  checks = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .ifIR(ifIR), .ifValid(ifValid),
    .wbEn(wbEn), .wbDR(wbDR), .wbCC(wbCC), .brTaken(brTaken), .intReq(intReq),
    .pause(pause), .flush(flush), .irq(irq), .intAck(intAck), .busyMask(busyMask)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] e(input logic p, input logic f, input logic i,
                                    input logic a, input logic [7:0] b);
    return {p, f, i, a, b};
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show in it.
  task automatic step(input string nm, input logic rs, input logic [15:0] ir,
                      input logic v, input logic we, input logic [2:0] wd,
                      input logic wc, input logic br, input logic iq,
                      input logic [11:0] ex);
    expT t;
    @(posedge clk);
    #1;
    reset = rs; ifIR = ir; ifValid = v; wbEn = we; wbDR = wd; wbCC = wc;
    brTaken = br; intReq = iq;
    t.nm = nm; t.exp = ex;
    expQ.push_back(t);
  endtask

  // Monitor: compare outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      mt = expQ.pop_front();
      checks++;
      if ({pause, flush, irq, intAck, busyMask} !== mt.exp) begin
        errors++;
        $display("FAIL %s: got pause=%b flush=%b irq=%b intAck=%b busyMask=%h, want pause=%b flush=%b irq=%b intAck=%b busyMask=%h",
                 mt.nm, pause, flush, irq, intAck, busyMask,
                 mt.exp[11], mt.exp[10], mt.exp[9], mt.exp[8], mt.exp[7:0]);
      end
    end
  end

  initial begin
    //     name     rst ir     v  we wd   wc br iq  expected {pause,flush,irq,ack,busy}
    step("reset",   1, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    // RAW on R1
    step("a1",      0, ADD1,  1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("a2",      0, ADD4,  1, 0, 3'd0, 0, 0, 0, e(1,0,0,0,8'h02));
    step("a3",      0, ADD4,  1, 0, 3'd0, 0, 0, 0, e(1,0,0,0,8'h02));
    step("a4wb",    0, ADD4,  1, 1, 3'd1, 1, 0, 0, e(1,0,0,0,8'h02));
    step("a5iss",   0, ADD4,  1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("a6",      0, IDLE,  0, 1, 3'd4, 1, 0, 0, e(0,0,0,0,8'h10));
    // BR waits on CC
    step("b1",      0, LD2,   1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("b2",      0, BRZ,   1, 0, 3'd0, 0, 0, 0, e(1,0,0,0,8'h04));
    step("b3wb",    0, BRZ,   1, 1, 3'd2, 1, 0, 0, e(1,0,0,0,8'h04));
    step("b4iss",   0, BRZ,   1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("b5",      0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    // squash on redirect, two flush cycles
    step("c1",      0, ADD5,  1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("c2br",    0, IDLE,  0, 0, 3'd0, 0, 1, 0, e(0,0,0,0,8'h20));
    step("c3fl",    0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(1,1,0,0,8'h00));
    step("c4fl",    0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(1,1,0,0,8'h00));
    step("c5",      0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    // interrupt drains an in-flight load
    step("d1",      0, LDR3,  1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("d2int",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(0,0,0,0,8'h08));
    step("d3drn",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,0,0,0,8'h08));
    step("d4wb",    0, IDLE,  0, 1, 3'd3, 1, 0, 1, e(1,0,0,0,8'h08));
    step("d5drn",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,0,0,0,8'h00));
    step("d6inj",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,0,1,1,8'h00));
    step("d7held",  0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(0,0,0,0,8'h00));
    step("d8held",  0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(0,0,0,0,8'h00));
    step("d9low",   0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("d10",     0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    // redirect and interrupt together: flush first, then drain, one ack
    step("e0",      0, ADD5,  1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("e1both",  0, IDLE,  0, 0, 3'd0, 0, 1, 1, e(0,0,0,0,8'h20));
    step("e2fl",    0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,1,0,0,8'h00));
    step("e3fl",    0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,1,0,0,8'h00));
    step("e4drn",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,0,0,0,8'h00));
    step("e5inj",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,0,1,1,8'h00));
    step("e6",      0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    // reset during DRAIN
    step("f1",      0, LDR3,  1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("f2int",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(0,0,0,0,8'h08));
    step("f3drn",   0, IDLE,  0, 0, 3'd0, 0, 0, 1, e(1,0,0,0,8'h08));
    step("f4rst",   1, IDLE,  0, 0, 3'd0, 0, 0, 1, e(0,0,0,0,8'h00));
    step("f5",      0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("f6",      0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    // reset during FLUSH
    step("g1br",    0, IDLE,  0, 0, 3'd0, 0, 1, 0, e(0,0,0,0,8'h00));
    step("g2rst",   1, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("g3",      0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    // counter saturation at 3, inc+dec same cycle, decrement at zero
    step("h1",      0, ADD10, 1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("h2",      0, ADD10, 1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h02));
    step("h3",      0, ADD10, 1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h02));
    step("h4full",  0, ADD10, 1, 0, 3'd0, 0, 0, 0, e(1,0,0,0,8'h02));
    step("h5wb",    0, ADD10, 1, 1, 3'd1, 1, 0, 0, e(1,0,0,0,8'h02));
    step("h6incdec",0, ADD10, 1, 1, 3'd1, 1, 0, 0, e(0,0,0,0,8'h02));
    step("h7",      0, ADD10, 1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h02));
    step("h8full",  0, ADD10, 1, 0, 3'd0, 0, 0, 0, e(1,0,0,0,8'h02));
    step("h9wb",    0, IDLE,  0, 1, 3'd1, 1, 0, 0, e(0,0,0,0,8'h02));
    step("h10wb",   0, IDLE,  0, 1, 3'd1, 1, 0, 0, e(0,0,0,0,8'h02));
    step("h11wb",   0, IDLE,  0, 1, 3'd1, 1, 0, 0, e(0,0,0,0,8'h02));
    step("h12zero", 0, IDLE,  0, 1, 3'd1, 1, 0, 0, e(0,0,0,0,8'h00));
    step("h13hold", 0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("h14",     0, ADD10, 1, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h00));
    step("h15",     0, IDLE,  0, 0, 3'd0, 0, 0, 0, e(0,0,0,0,8'h02));

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
